// File: rtl/pu_transfer_master_if.sv
// PU transfer bus bundle: command handshake, PU read/write strobes,
// shared OR-combined return bus and status pulses.
interface pu_transfer_master_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ATTR_WIDTH = 4,
    parameter int N_PU       = 4,
    parameter int SRC_WIDTH  = 2
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [SRC_WIDTH-1:0]  cmd_src;
    logic [N_PU-1:0]       cmd_dst;
    logic [N_PU-1:0]       signal_oe;
    logic [DATA_WIDTH-1:0] bus_data_in;
    logic [ATTR_WIDTH-1:0] bus_attr_in;
    logic [N_PU-1:0]       signal_wr;
    logic [DATA_WIDTH-1:0] data_out;
    logic [ATTR_WIDTH-1:0] attr_out;
    logic                  done;
    logic                  err_src;
    logic                  err_invalid;
    logic                  err_bus;

    modport master (
        input  cmd_valid, cmd_src, cmd_dst, bus_data_in, bus_attr_in,
        output cmd_ready, signal_oe, signal_wr, data_out, attr_out,
        output done, err_src, err_invalid, err_bus
    );

    modport slave (
        output cmd_valid, cmd_src, cmd_dst, bus_data_in, bus_attr_in,
        input  cmd_ready, signal_oe, signal_wr, data_out, attr_out,
        input  done, err_src, err_invalid, err_bus
    );
endinterface

// File: rtl/pu_transfer_master.sv
// Sequencer moving one word from a source PU to a mask of destination PUs.
// Optional bus contention check: PU_TRANSFER_MASTER_BUS_CHECK_EN.
module pu_transfer_master #(
    parameter int DATA_WIDTH = 32,
    parameter int ATTR_WIDTH = 4,
    parameter int N_PU       = 4,
    parameter int SRC_WIDTH  = 2
) (
    input logic clk,
    input logic rst_n,
    pu_transfer_master_if.master bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READ    = 2'd1,
        CAPTURE = 2'd2,
        WRITE   = 2'd3
    } state_t;

    localparam logic [SRC_WIDTH:0] SRC_LIMIT = (SRC_WIDTH+1)'(N_PU);
    localparam logic [N_PU-1:0]    ONE_HOT0  = N_PU'(1);

    state_t                state;
    state_t                state_nxt;
    logic [SRC_WIDTH-1:0]  src_q;
    logic [N_PU-1:0]       dst_q;
    logic [DATA_WIDTH-1:0] buf_data;
    logic [ATTR_WIDTH-1:0] buf_attr;
    logic                  err_src_q;
    logic                  accept;
    logic                  src_bad;

    assign accept  = (state == IDLE) && bus.cmd_valid;
    assign src_bad = {1'b0, bus.cmd_src} >= SRC_LIMIT;

    // State register; reset abandons any in-flight transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state: a rejected source keeps the sequencer in IDLE.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept && !src_bad) state_nxt = READ;
            READ:    state_nxt = CAPTURE;
            CAPTURE: state_nxt = WRITE;
            WRITE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Latch the accepted command so it is stable for the whole transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_q <= '0;
            dst_q <= '0;
        end else if (accept && !src_bad) begin
            src_q <= bus.cmd_src;
            dst_q <= bus.cmd_dst;
        end
    end

    // Sample the returned word at the end of CAPTURE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_data <= '0;
            buf_attr <= '0;
        end else if (state == CAPTURE) begin
            buf_data <= bus.bus_data_in;
            buf_attr <= bus.bus_attr_in;
        end
    end

    // Out-of-range source is reported the cycle after the rejecting edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_src_q <= 1'b0;
        else        err_src_q <= accept && src_bad;
    end

`ifdef PU_TRANSFER_MASTER_BUS_CHECK_EN
    logic err_bus_q;
    logic bus_nz;

    assign bus_nz = (|bus.bus_data_in) || (|bus.bus_attr_in);

    // With oe one-hot, contention shows up as a live bus while no PU is
    // expected to drive it, i.e. in IDLE and READ.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_bus_q <= 1'b0;
        else        err_bus_q <= bus_nz &&
                                 ((state == IDLE) || (state == READ));
    end

    assign bus.err_bus = err_bus_q;
`else
    assign bus.err_bus = 1'b0;
`endif

    assign bus.err_src = err_src_q;

    // Outputs decoded from state; data lines stay 0 outside WRITE.
    always_comb begin
        bus.cmd_ready   = 1'b0;
        bus.signal_oe   = '0;
        bus.signal_wr   = '0;
        bus.data_out    = '0;
        bus.attr_out    = '0;
        bus.done        = 1'b0;
        bus.err_invalid = 1'b0;
        unique case (state)
            IDLE: bus.cmd_ready = 1'b1;
            READ: bus.signal_oe = ONE_HOT0 << src_q;
            CAPTURE: ;
            WRITE: begin
                bus.signal_wr   = dst_q;
                bus.data_out    = buf_data;
                bus.attr_out    = buf_attr;
                bus.done        = 1'b1;
                bus.err_invalid = buf_attr[0];
            end
            default: ;
        endcase
    end

endmodule
